// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder: funct3 width codes, FSM encoding, word offset.
// No logic; imported by dmem_responder and dmem_lane_align.
// No flow control of its own.
package dmem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int ADDR_LSB = 2;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32I loads/stores: store byte-enables and replicated data, load extension, width faults.
// Purely combinational, zero latency.
// No flow control; the caller qualifies the outputs.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic        write,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        misalign,
  output logic        illegal
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rword[{addr_lo, 3'b000} +: 8];
  assign rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    be        = 4'b0000;
    wdata_sh  = wdata;
    rdata_ext = 32'd0;
    misalign  = 1'b0;
    illegal   = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        be        = 4'b0001 << addr_lo;
        wdata_sh  = {4{wdata[7:0]}};
        rdata_ext = funct3[2] ? {24'd0, rbyte} : {{24{rbyte[7]}}, rbyte};
      end
      F3_H, F3_HU: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_sh  = {2{wdata[15:0]}};
        rdata_ext = funct3[2] ? {16'd0, rhalf} : {{16{rhalf[15]}}, rhalf};
        misalign  = addr_lo[0];
      end
      F3_W: begin
        be        = 4'b1111;
        rdata_ext = rword;
        misalign  = (addr_lo != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
    // Unsigned variants exist only as loads.
    if (write && funct3[2])
      illegal = 1'b1;
  end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory target: one load/store in flight, byte/half/word access with fault reporting.
// Response valid LATENCY+1 cycles after the accepting cycle (LATENCY wait cycles, 0..15).
// Response held until rsp_ready; req_ready low from acceptance until the response handshake.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [2:0]  lat_funct3;

  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        do_access;
  logic        cur_write;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [2:0]  cur_funct3;
  logic [AW-1:0] idx;
  logic        oor;
  logic [31:0] rword;
  logic [31:0] wmerge;
  logic [3:0]  be;
  logic [31:0] wdata_sh;
  logic [31:0] rdata_ext;
  logic        misalign;
  logic        illegal;
  logic        err;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid & req_ready;

  // With zero latency the access happens on the accepting edge, so it must see the live request.
  assign cur_write  = (state == IDLE) ? req_write  : lat_write;
  assign cur_addr   = (state == IDLE) ? req_addr   : lat_addr;
  assign cur_wdata  = (state == IDLE) ? req_wdata  : lat_wdata;
  assign cur_funct3 = (state == IDLE) ? req_funct3 : lat_funct3;

  assign do_access = ((state == IDLE) && accept && (LATENCY == 0)) ||
                     ((state == WAIT) && (cnt == 4'd0));

  assign idx   = cur_addr[ADDR_LSB +: AW];
  assign oor   = (cur_addr >> (ADDR_LSB + AW)) != 32'd0;
  assign rword = mem[idx];

  dmem_lane_align u_align (
    .write     (cur_write),
    .addr_lo   (cur_addr[1:0]),
    .funct3    (cur_funct3),
    .wdata     (cur_wdata),
    .rword     (rword),
    .be        (be),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext),
    .misalign  (misalign),
    .illegal   (illegal)
  );

  assign err = illegal | misalign | oor;

  assign wmerge = {be[3] ? wdata_sh[31:24] : rword[31:24],
                   be[2] ? wdata_sh[23:16] : rword[23:16],
                   be[1] ? wdata_sh[15:8]  : rword[15:8],
                   be[0] ? wdata_sh[7:0]   : rword[7:0]};

  // Contents survive reset; the reset gate keeps an aborted access from committing.
  always_ff @(posedge clk) begin
    if (reset && do_access && cur_write && !err)
      mem[idx] <= wmerge;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      lat_write  <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      lat_funct3 <= 3'd0;
      rsp_rdata  <= 32'd0;
      rsp_err    <= 1'b0;
    end else begin
      if (do_access) begin
        rsp_err   <= err;
        rsp_rdata <= (err || cur_write) ? 32'd0 : rdata_ext;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            lat_write  <= req_write;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            lat_funct3 <= req_funct3;
            if (LATENCY == 0) begin
              state <= RESP;
            end else begin
              cnt   <= CNT_INIT;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0)
            state <= RESP;
          else
            cnt <= cnt - 4'd1;
        end
        RESP: begin
          if (rsp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one LATENCY=2 and one LATENCY=0 instance share stimulus via a select.
// A byte-level memory model predicts each response; a monitor checks timing, data, error and hold behaviour.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int DEPTH = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        use0;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_ready;

  logic        rr2, rv2, re2, rr0, rv0, re0;
  logic [31:0] rd2, rd0;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & ~use0), .req_ready(rr2),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rv2), .rsp_ready(rsp_ready & ~use0), .rsp_rdata(rd2), .rsp_err(re2)
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & use0), .req_ready(rr0),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rv0), .rsp_ready(rsp_ready & use0), .rsp_rdata(rd0), .rsp_err(re0)
  );

  logic        m_req_ready, m_rsp_valid, m_rsp_err;
  logic [31:0] m_rsp_rdata;
  int          lat;
  assign m_req_ready = use0 ? rr0 : rr2;
  assign m_rsp_valid = use0 ? rv0 : rv2;
  assign m_rsp_err   = use0 ? re0 : re2;
  assign m_rsp_rdata = use0 ? rd0 : rd2;
  assign lat         = use0 ? 0 : 2;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference memories, one per instance.
  logic [31:0] mem2 [DEPTH];
  logic [31:0] mem0 [DEPTH];

  task automatic model_op(input logic s, input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f3, output logic [31:0] rd, output logic e);
    int nb, off, wi;
    logic illegal, mis, oor;
    logic [31:0] word, mask;
    illegal = w ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    nb  = 1 << f3[1:0];
    off = int'(a[1:0]);
    mis = (int'(a[2:0]) % nb) != 0;
    oor = a >= 32'(4 * DEPTH);
    e   = illegal | mis | oor;
    rd  = 32'd0;
    if (!e) begin
      wi   = int'(a >> 2);
      word = s ? mem0[wi] : mem2[wi];
      if (w) begin
        for (int k = 0; k < nb; k++)
          word[8*(off+k) +: 8] = wd[8*k +: 8];
        if (s) mem0[wi] = word;
        else   mem2[wi] = word;
      end else begin
        rd = word >> (8 * off);
        if (nb < 4) begin
          mask = (32'd1 << (8 * nb)) - 32'd1;
          rd   = rd & mask;
          if (!f3[2] && rd[8*nb-1]) rd = rd | ~mask;
        end
      end
    end
  endtask

  typedef struct {
    logic [31:0] rd;
    logic        e;
    int          acc;
  } exp_t;
  exp_t sbq[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor, which also owns rsp_ready so it knows when each handshake lands.
  logic        in_rsp = 1'b0;
  logic [31:0] held_rd;
  logic        held_e;
  int          stall = 0;
  logic        stall_arm = 1'b0;
  exp_t        mex;

  always @(negedge clk) begin
    if (!reset) begin
      in_rsp = 1'b0;
    end else if (m_rsp_valid) begin
      chk1("req_ready_low_while_rsp", m_req_ready, 1'b0);
      if (!in_rsp) begin
        if (sbq.size() == 0) begin
          fail_now("unexpected_rsp");
        end else begin
          mex = sbq.pop_front();
          chk("rsp_latency", 32'(cyc), 32'(mex.acc + lat));
          chk("rsp_rdata", m_rsp_rdata, mex.rd);
          chk1("rsp_err", m_rsp_err, mex.e);
          held_rd = m_rsp_rdata;
          held_e  = m_rsp_err;
          in_rsp  = 1'b1;
          if (stall_arm) begin
            stall     = 5;
            stall_arm = 1'b0;
          end
        end
      end else begin
        chk("hold_rdata", m_rsp_rdata, held_rd);
        chk1("hold_err", m_rsp_err, held_e);
      end
    end
    if (stall > 0) begin
      rsp_ready = 1'b0;
      stall--;
    end else begin
      rsp_ready = ($urandom_range(99) < 70);
    end
    if (m_rsp_valid && rsp_ready) in_rsp = 1'b0;
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
    exp_t ex;
    int n;
    logic [31:0] rd;
    logic e;
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_wdata  = wd;
    req_funct3 = f3;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_req_ready && n < 300);
    if (!m_req_ready) begin
      fail_now("accept_timeout");
      req_valid = 1'b0;
      return;
    end
    chk1("no_rsp_at_accept", m_rsp_valid, 1'b0);
    model_op(use0, w, a, wd, f3, rd, e);
    @(posedge clk);
    #1;
    ex.rd  = rd;
    ex.e   = e;
    ex.acc = cyc;
    sbq.push_back(ex);
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_funct3 = 3'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() > 0 || m_rsp_valid) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (sbq.size() > 0 || m_rsp_valid) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic rand_op();
    logic [31:0] a;
    logic [2:0]  f3;
    a = $urandom_range(4 * DEPTH + 7);
    if ($urandom_range(15) == 0) a = $urandom;
    if ($urandom_range(9) < 8) begin
      case ($urandom_range(4))
        0: f3 = F3_B;
        1: f3 = F3_H;
        2: f3 = F3_W;
        3: f3 = F3_BU;
        default: f3 = F3_HU;
      endcase
    end else begin
      f3 = 3'($urandom_range(7));
    end
    issue(1'($urandom), a, $urandom, f3);
    repeat ($urandom_range(2)) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; use0 = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; req_funct3 = 3'd0; rsp_ready = 1'b0;
    #12;
    chk1("rst_req_ready_l2", rr2, 1'b1);
    chk1("rst_rsp_valid_l2", rv2, 1'b0);
    chk("rst_rdata_l2", rd2, 32'd0);
    chk1("rst_err_l2", re2, 1'b0);
    chk1("rst_req_ready_l0", rr0, 1'b1);
    chk1("rst_rsp_valid_l0", rv0, 1'b0);
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #1;

    for (int s = 0; s < 2; s++) begin
      use0 = 1'(s);
      for (int i = 0; i < DEPTH; i++) issue(1'b1, 32'(4 * i), $urandom, F3_W);
      drain();
    end

    use0 = 1'b0;
    issue(1'b1, 32'h10, 32'hDEADBEEF, F3_W);
    issue(1'b0, 32'h10, 32'h0, F3_W);
    issue(1'b1, 32'h11, 32'h000000A5, F3_B);
    issue(1'b0, 32'h11, 32'h0, F3_B);
    issue(1'b0, 32'h11, 32'h0, F3_BU);
    issue(1'b0, 32'h12, 32'h0, F3_H);
    issue(1'b0, 32'h12, 32'h0, F3_HU);
    issue(1'b0, 32'h13, 32'h0, F3_W);
    issue(1'b0, 32'h10, 32'h0, F3_W);
    issue(1'b1, 32'(4 * DEPTH), 32'h12345678, F3_W);
    issue(1'b1, 32'h20, 32'hCAFEF00D, 3'b100);
    issue(1'b0, 32'h20, 32'h0, F3_W);
    issue(1'b0, 32'h0, 32'h0, F3_W);
    drain();

    // Backpressure with a second request waiting behind the held response.
    stall_arm = 1'b1;
    issue(1'b0, 32'h10, 32'h0, F3_W);
    issue(1'b0, 32'h11, 32'h0, F3_BU);
    drain();

    for (int i = 0; i < 200; i++) rand_op();
    drain();

    // Reset while the load sits in WAIT.
    issue(1'b0, 32'h10, 32'h0, F3_W);
    #1 reset = 1'b0;
    #1;
    chk1("midwait_rst_rsp_valid", rv2, 1'b0);
    chk1("midwait_rst_req_ready", rr2, 1'b1);
    sbq.delete();
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #1;
    issue(1'b0, 32'h10, 32'h0, F3_W);
    drain();

    use0 = 1'b1;
    @(posedge clk); #1;
    issue(1'b1, 32'h10, 32'hDEADBEEF, F3_W);
    issue(1'b0, 32'h10, 32'h0, F3_W);
    issue(1'b1, 32'h13, 32'h0000005A, F3_B);
    issue(1'b0, 32'h13, 32'h0, F3_B);
    issue(1'b0, 32'h12, 32'h0, F3_HU);
    for (int i = 0; i < 100; i++) rand_op();
    drain();

    // Reset while a committed store's response is held; the store must persist.
    stall = 10;
    issue(1'b1, 32'h40, 32'h0BADF00D, F3_W);
    #1 reset = 1'b0;
    #1;
    chk1("resp_rst_rsp_valid_l0", rv0, 1'b0);
    chk1("resp_rst_req_ready_l0", rr0, 1'b1);
    sbq.delete();
    stall = 0;
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #1;
    issue(1'b0, 32'h40, 32'h0, F3_W);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

endmodule
